// File: rtl/nn_vote_filter.sv
// nn_vote_filter: sliding-window majority vote over classifier decisions.
// Keeps the last DEPTH accepted species codes, tracks a vote counter per
// class, and publishes a registered majority species, its vote count, the
// window fill level, a stability flag and a one-cycle change strobe.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset (overrides everything)
//   clear_i        synchronous window flush (keeps reject counter)
//   in_valid_i     new classification present on species_i / final_i
//   species_i      class code from the classifier
//   final_i        unsigned classifier score
//   out_valid_o    outputs reflect a newly accepted sample (one cycle)
//   maj_species_o  majority class, 4'hF when the window is empty
//   maj_count_o    votes held by maj_species_o
//   fill_o         accepted samples in window, saturates at DEPTH
//   stable_o       maj_count_o >= THRESH
//   change_o       one-cycle pulse when the stable decision switches
//   reject_cnt_o   rejected samples, saturating at 255
module nn_vote_filter #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_CLASSES = 3,
  parameter int unsigned THRESH      = 5,
  parameter int unsigned MIN_SCORE   = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        in_valid_i,
  input  logic [3:0]  species_i,
  input  logic [31:0] final_i,
  output logic        out_valid_o,
  output logic [3:0]  maj_species_o,
  output logic [3:0]  maj_count_o,
  output logic [3:0]  fill_o,
  output logic        stable_o,
  output logic        change_o,
  output logic [7:0]  reject_cnt_o
);

  // Class index width: at most four classes, so two bits per window slot.
  localparam int unsigned CW = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned RW = 8;
  localparam logic [3:0] NONE = 4'hF;

  // Window / counter stage (updated on the accepting edge).
  logic [CW-1:0] win_q [DEPTH];
  logic [CW-1:0] win_d [DEPTH];
  logic [NW-1:0] cnt_q [NUM_CLASSES];
  logic [NW-1:0] cnt_d [NUM_CLASSES];
  logic [NW-1:0] fill_q, fill_d;
  logic          pend_q;

  // Published result stage (updated one edge after acceptance).
  logic          out_valid_q;
  logic [3:0]    maj_q, maj_d;
  logic [NW-1:0] count_q;
  logic [NW-1:0] fill_out_q;
  logic          stable_q, stable_d;
  logic          change_q, change_d;
  logic [3:0]    last_q;
  logic [RW-1:0] reject_q;

  logic          accept_c;
  logic          reject_c;
  logic          evict_c;
  logic [CW-1:0] new_cls_c;
  logic [CW-1:0] old_cls_c;
  logic [NW-1:0] best_cnt_c;
  logic [CW-1:0] best_idx_c;
  logic          keep_c;

  // Sample qualification; clear suppresses both acceptance and rejection.
  always_comb begin
    accept_c  = in_valid_i && !clear_i
                && (species_i < 4'(NUM_CLASSES))
                && (final_i >= 32'(MIN_SCORE));
    reject_c  = in_valid_i && !clear_i && !accept_c;
    new_cls_c = species_i[CW-1:0];
    old_cls_c = win_q[DEPTH-1];
    evict_c   = (fill_q == NW'(DEPTH));
  end

  // Shift the new code in; when full, the oldest slot is retired so its
  // counter drops on the same edge the new counter rises.
  always_comb begin
    win_d  = win_q;
    cnt_d  = cnt_q;
    fill_d = fill_q;
    if (accept_c) begin
      win_d[0] = new_cls_c;
      for (int i = 1; i < int'(DEPTH); i++) begin
        win_d[i] = win_q[i-1];
      end
      if (!evict_c) begin
        fill_d = fill_q + NW'(1);
      end
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        cnt_d[c] = cnt_q[c]
                   + NW'(new_cls_c == CW'(c))
                   - NW'(evict_c && (old_cls_c == CW'(c)));
      end
    end
  end

  // Majority over the current counters. Ascending scan with strict '>'
  // yields the lowest tied index; an incumbent that is still tied wins.
  always_comb begin
    best_cnt_c = '0;
    best_idx_c = '0;
    keep_c     = 1'b0;
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      if (cnt_q[c] > best_cnt_c) begin
        best_cnt_c = cnt_q[c];
        best_idx_c = CW'(c);
      end
    end
    for (int c = 0; c < int'(NUM_CLASSES); c++) begin
      if ((maj_q == 4'(c)) && (cnt_q[c] == best_cnt_c)) begin
        keep_c = 1'b1;
      end
    end
    if (best_cnt_c == '0) begin
      maj_d = NONE;
    end else if (keep_c) begin
      maj_d = maj_q;
    end else begin
      maj_d = 4'(best_idx_c);
    end
    stable_d = (best_cnt_c >= NW'(THRESH));
    change_d = stable_d && (maj_d != last_q);
  end

  // Window, counters and fill.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        win_q[i] <= '0;
      end
      for (int c = 0; c < int'(NUM_CLASSES); c++) begin
        cnt_q[c] <= '0;
      end
      fill_q <= '0;
      pend_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      pend_q <= accept_c;
    end
  end

  // Published result, registered one edge after the accepting edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      out_valid_q <= 1'b0;
      maj_q       <= NONE;
      count_q     <= '0;
      fill_out_q  <= '0;
      stable_q    <= 1'b0;
      change_q    <= 1'b0;
      last_q      <= NONE;
    end else begin
      out_valid_q <= pend_q;
      change_q    <= 1'b0;
      if (pend_q) begin
        maj_q      <= maj_d;
        count_q    <= best_cnt_c;
        fill_out_q <= fill_q;
        stable_q   <= stable_d;
        change_q   <= change_d;
        if (change_d) begin
          last_q <= maj_d;
        end
      end
    end
  end

  // Saturating reject counter; survives clear, not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reject_q <= '0;
    end else if (reject_c && (reject_q != {RW{1'b1}})) begin
      reject_q <= reject_q + RW'(1);
    end
  end

  assign out_valid_o   = out_valid_q;
  assign maj_species_o = maj_q;
  assign maj_count_o   = count_q;
  assign fill_o        = fill_out_q;
  assign stable_o      = stable_q;
  assign change_o      = change_q;
  assign reject_cnt_o  = reject_q;

endmodule

// File: tb/tb_nn_vote_filter.sv
module tb_nn_vote_filter;

  localparam int DEPTH = 8;
  localparam int NC    = 3;
  localparam int THR   = 5;
  localparam int MINS  = 1;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [3:0]  species;
  logic [31:0] final_s;
  logic        out_valid;
  logic [3:0]  maj_species;
  logic [3:0]  maj_count;
  logic [3:0]  fill;
  logic        stable;
  logic        change;
  logic [7:0]  reject_cnt;

  nn_vote_filter #(
    .DEPTH(DEPTH), .NUM_CLASSES(NC), .THRESH(THR), .MIN_SCORE(MINS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid),
    .species_i(species), .final_i(final_s),
    .out_valid_o(out_valid), .maj_species_o(maj_species),
    .maj_count_o(maj_count), .fill_o(fill), .stable_o(stable),
    .change_o(change), .reject_cnt_o(reject_cnt)
  );

  typedef struct packed {
    logic [3:0] maj;
    logic [3:0] cnt;
    logic [3:0] fill;
    logic       stable;
    logic       change;
  } exp_t;

  exp_t sb[$];
  int   win[$];          // reference window, newest at front
  int   cur_maj;
  int   last_stable;
  int   rej;
  bit   prev_acc;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: recount the window, apply the majority/tie rules directly.
  task automatic model_accept(input int sp);
    int cnt[NC];
    int best;
    int nmaj;
    bit stb;
    bit chg;
    exp_t e;
    win.push_front(sp);
    if (win.size() > DEPTH) void'(win.pop_back());
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    foreach (win[i]) cnt[win[i]]++;
    best = 0;
    for (int c = 0; c < NC; c++) if (cnt[c] > best) best = cnt[c];
    if (best == 0) nmaj = 15;
    else if (cur_maj < NC && cnt[cur_maj] == best) nmaj = cur_maj;
    else begin
      nmaj = -1;
      for (int c = 0; c < NC; c++) if (nmaj < 0 && cnt[c] == best) nmaj = c;
    end
    stb = (best >= THR);
    chg = stb && (nmaj != last_stable);
    if (chg) last_stable = nmaj;
    cur_maj = nmaj;
    e.maj = 4'(nmaj); e.cnt = 4'(best); e.fill = 4'(win.size());
    e.stable = stb; e.change = chg;
    sb.push_back(e);
  endtask

  task automatic model_flush();
    // A sample accepted on the previous edge never gets published.
    if (prev_acc && sb.size() > 0) void'(sb.pop_back());
    win.delete();
    cur_maj = 15;
    last_stable = 15;
    prev_acc = 0;
  endtask

  task automatic drive(input bit v, input bit clr, input logic [3:0] sp, input logic [31:0] f);
    bit acc;
    in_valid = v; clear = clr; species = sp; final_s = f;
    acc = v && !clr && (int'(sp) < NC) && (f >= 32'(MINS));
    if (clr) model_flush();
    else if (acc) model_accept(int'(sp));
    else if (v) rej = (rej == 255) ? 255 : rej + 1;
    prev_acc = acc;
    @(posedge clk); #1;
    in_valid = 0; clear = 0;
    check("reject_cnt", 32'(reject_cnt), 32'(rej));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 32'd0);
  endtask

  task automatic do_reset(input bit v);
    rst = 1; in_valid = v; species = 4'd2; final_s = 32'd9;
    model_flush();
    rej = 0;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_maj", 32'(maj_species), 15);
    check("rst_count", 32'(maj_count), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_stable", 32'(stable), 0);
    check("rst_change", 32'(change), 0);
    check("rst_reject", 32'(reject_cnt), 0);
  endtask

  // Monitor: every published result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("maj_species", 32'(maj_species), 32'(e.maj));
          check("maj_count", 32'(maj_count), 32'(e.cnt));
          check("fill", 32'(fill), 32'(e.fill));
          check("stable", 32'(stable), 32'(e.stable));
          check("change", 32'(change), 32'(e.change));
        end
      end
    end
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1; clear = 0; in_valid = 0; species = 0; final_s = 0;
    cur_maj = 15; last_stable = 15; rej = 0; prev_acc = 0;
    @(posedge clk);
    do_reset(0);

    // Five votes for class 1 reach the threshold.
    for (int i = 0; i < 5; i++) drive(1, 0, 4'd1, 32'd100);
    idle(2);
    check("t1_maj", 32'(maj_species), 1);
    check("t1_stable", 32'(stable), 1);

    // Class 2 takes over through a tie that keeps the incumbent.
    for (int i = 0; i < 5; i++) drive(1, 0, 4'd2, 32'd100);
    idle(2);
    check("t2_maj", 32'(maj_species), 2);
    check("t2_count", 32'(maj_count), 5);

    // Bad class and low score are rejected without touching the window.
    drive(1, 0, 4'd3, 32'd50);
    drive(1, 0, 4'd0, 32'd0);
    idle(2);
    check("t3_reject", 32'(reject_cnt), 2);
    check("t3_maj", 32'(maj_species), 2);
    check("t3_count", 32'(maj_count), 5);
    check("t3_fill", 32'(fill), 8);

    // Clear beats a simultaneous sample.
    drive(1, 1, 4'd0, 32'd10);
    check("t4_fill", 32'(fill), 0);
    check("t4_maj", 32'(maj_species), 15);
    check("t4_stable", 32'(stable), 0);
    check("t4_out_valid", 32'(out_valid), 0);
    check("t4_reject", 32'(reject_cnt), 2);
    drive(1, 0, 4'd0, 32'd10);
    idle(2);
    check("t4_count", 32'(maj_count), 1);

    // Reject counter saturates.
    for (int i = 0; i < 300; i++) drive(1, 0, 4'd3, 32'd7);
    check("t5_reject_sat", 32'(reject_cnt), 255);

    // Reset in the middle of a stream, right after an accepted sample.
    drive(1, 0, 4'd0, 32'd5);
    drive(1, 0, 4'd0, 32'd5);
    do_reset(1);
    drive(1, 0, 4'd1, 32'd5);
    idle(2);
    check("t6_fill", 32'(fill), 1);

    // Randomized traffic with occasional clear and reset.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [3:0]  sp;
      logic [31:0] f;
      r  = int'($urandom_range(0, 99));
      sp = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, NC - 1));
      f  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if (r < 2)       drive(1, 1, sp, f);
      else if (r < 3)  do_reset($urandom_range(0, 1) == 1);
      else if (r < 80) drive(1, 0, sp, f);
      else             drive(0, 0, sp, f);
    end

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    check("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
